// File: rtl/branch_predictor.sv
// Fetch-side next-PC predictor: direct-mapped BTB with 2-bit counters, trained by the execute-stage resolution stream.
// Latency: lookup is combinational (zero cycles); training becomes visible on the cycle after the update edge.
// Backpressure: none issued; rdy=0 freezes the table and statistics, and a resolution offered then is dropped.
module branch_predictor #(
  parameter int         IDX_W    = 6,
  parameter int         TAG_W    = 24,
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] if_pc,
  output logic [31:0] pred_pc,
  output logic        pred_taken,
  input  logic        br_flag,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_to,
  input  logic        br_taken,
  input  logic        br_mispredict,
  output logic [31:0] br_cnt,
  output logic [31:0] mis_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  // Table storage: valid and counters are reset, tags and targets are plain RAM.
  logic             valid_q  [DEPTH];
  logic [1:0]       ctr_q    [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];

  // Fetch-side lookup fields.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  // Resolution-side update fields.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_en;
  logic             up_hit;
  logic             up_alloc;
  logic             up_wr_target;
  logic [1:0]       up_ctr;

  // The byte offset of a resolved PC never reaches the table.
  logic unused_br_pc_lsb;
  assign unused_br_pc_lsb = ^br_pc[1:0];

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[31:IDX_W+2];
  assign up_idx = br_pc[IDX_W+1:2];
  assign up_tag = br_pc[31:IDX_W+2];

  // Predict from pre-edge table state; a same-cycle update is deliberately not bypassed.
  always_comb begin
    lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken = 1'b0;
    pred_pc    = if_pc + 32'd4;
    if (lk_hit && ctr_q[lk_idx][1]) begin
      pred_taken = 1'b1;
      pred_pc    = target_q[lk_idx];
    end
  end

  // Decide what a resolution does to its entry: train the counter on a hit, allocate on a taken miss.
  always_comb begin
    up_en        = rdy && br_flag;
    up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_alloc     = up_en && !up_hit && br_taken;
    up_wr_target = up_en && br_taken;
    up_ctr       = ctr_q[up_idx];
    if (up_alloc) begin
      up_ctr = CTR_INIT;
    end else if (up_hit && br_taken) begin
      up_ctr = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01;
    end else if (up_hit) begin
      up_ctr = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01;
    end
  end

  // Valid bits and counters: cleared by reset, trained by accepted resolutions.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (up_en) begin
      ctr_q[up_idx] <= up_ctr;
      if (up_alloc) begin
        valid_q[up_idx] <= 1'b1;
      end
    end
  end

  // Tag and target RAM: written on allocation, target refreshed on every taken resolution.
  always_ff @(posedge clk) begin
    if (!rst && up_wr_target) begin
      target_q[up_idx] <= br_to;
      if (up_alloc) begin
        tag_q[up_idx] <= up_tag;
      end
    end
  end

  // Statistics: every accepted resolution counts, mispredicts only when flagged with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt  <= 32'd0;
      mis_cnt <= 32'd0;
    end else if (up_en) begin
      br_cnt <= br_cnt + 32'd1;
      if (br_mispredict) begin
        mis_cnt <= mis_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed training vectors from a table plus hand-written corner sequences.
// Latency: each vector trains on one edge and checks the prediction on the following cycle.
// Backpressure: exercises rdy=0 freeze and reset dominating a pending resolution.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] if_pc;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        br_flag;
  logic [31:0] br_pc;
  logic [31:0] br_to;
  logic        br_taken;
  logic        br_mispredict;
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        flag;
    logic [31:0] pc;
    logic [31:0] to;
    logic        tk;
    logic        mis;
    logic [31:0] chk_pc;
    logic [31:0] exp_pred;
    logic        exp_tk;
    logic [31:0] exp_br;
    logic [31:0] exp_mis;
  } vec_t;

  vec_t vecs[14];

  branch_predictor #(.IDX_W(6), .TAG_W(24), .CTR_INIT(2'b10)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .if_pc         (if_pc),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .br_flag       (br_flag),
    .br_pc         (br_pc),
    .br_to         (br_to),
    .br_taken      (br_taken),
    .br_mispredict (br_mispredict),
    .br_cnt        (br_cnt),
    .mis_cnt       (mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [31:0] e_pred, input logic e_tk,
                         input logic [31:0] e_br, input logic [31:0] e_mis);
    chk({name, ".pred_pc"}, pred_pc, e_pred);
    chk({name, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, e_tk});
    chk({name, ".br_cnt"}, br_cnt, e_br);
    chk({name, ".mis_cnt"}, mis_cnt, e_mis);
  endtask

  function automatic vec_t mk(input logic f, input logic [31:0] p, input logic [31:0] t,
                              input logic k, input logic m, input logic [31:0] c,
                              input logic [31:0] ep, input logic ek,
                              input logic [31:0] eb, input logic [31:0] em);
    vec_t v;
    v.flag = f; v.pc = p; v.to = t; v.tk = k; v.mis = m;
    v.chk_pc = c; v.exp_pred = ep; v.exp_tk = ek; v.exp_br = eb; v.exp_mis = em;
    return v;
  endfunction

  // Present one resolution at the negedge, let the posedge take it, then look up chk_pc.
  task automatic drive_upd(input logic f, input logic [31:0] p, input logic [31:0] t,
                           input logic k, input logic m);
    @(negedge clk);
    br_flag = f; br_pc = p; br_to = t; br_taken = k; br_mispredict = m;
    @(posedge clk);
    #1;
    br_flag = 1'b0;
    br_mispredict = 1'b0;
  endtask

  initial begin
    // Training stream starting right after the first taken resolution at 0x1000 (ctr=10, counts 1/1).
    vecs[0]  = mk(1, 32'h1000, 32'h1004, 0, 1, 32'h1000, 32'h1004, 0, 2, 2);
    vecs[1]  = mk(1, 32'h1000, 32'h1004, 0, 0, 32'h1000, 32'h1004, 0, 3, 2);
    vecs[2]  = mk(1, 32'h1000, 32'h1004, 0, 0, 32'h1000, 32'h1004, 0, 4, 2);
    vecs[3]  = mk(1, 32'h1000, 32'h0F00, 1, 1, 32'h1000, 32'h1004, 0, 5, 3);
    vecs[4]  = mk(1, 32'h1000, 32'h0F00, 1, 1, 32'h1000, 32'h0F00, 1, 6, 4);
    vecs[5]  = mk(1, 32'h1100, 32'h2000, 1, 1, 32'h1100, 32'h2000, 1, 7, 5);
    vecs[6]  = mk(0, 32'h1000, 32'h0F00, 1, 1, 32'h1000, 32'h1004, 0, 7, 5);
    vecs[7]  = mk(1, 32'h3004, 32'h3008, 0, 0, 32'h3004, 32'h3008, 0, 8, 5);
    vecs[8]  = mk(0, 32'h0, 32'h0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000, 0, 8, 5);
    vecs[9]  = mk(1, 32'h1100, 32'h2000, 1, 0, 32'h1100, 32'h2000, 1, 9, 5);
    vecs[10] = mk(1, 32'h1100, 32'h2100, 1, 0, 32'h1100, 32'h2100, 1, 10, 5);
    vecs[11] = mk(1, 32'h1100, 32'h1104, 0, 1, 32'h1100, 32'h2100, 1, 11, 6);
    vecs[12] = mk(0, 32'h0, 32'h0, 0, 0, 32'h1102, 32'h2100, 1, 11, 6);
    vecs[13] = mk(1, 32'h1100, 32'h1104, 0, 0, 32'h1100, 32'h1104, 0, 12, 6);

    rst = 1'b1; rdy = 1'b1; if_pc = 32'h1000;
    br_flag = 1'b0; br_pc = '0; br_to = '0; br_taken = 1'b0; br_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_all("reset", 32'h1004, 1'b0, 0, 0);

    // Same-cycle lookup and update of one entry: old state this cycle, new state next cycle.
    @(negedge clk);
    if_pc = 32'h1000;
    br_flag = 1'b1; br_pc = 32'h1000; br_to = 32'h0F00; br_taken = 1'b1; br_mispredict = 1'b1;
    #1;
    chk("same_cycle.pred_pc", pred_pc, 32'h1004);
    chk("same_cycle.pred_taken", {31'd0, pred_taken}, 32'd0);
    @(posedge clk);
    #1;
    br_flag = 1'b0; br_mispredict = 1'b0;
    #1;
    chk_all("first_alloc", 32'h0F00, 1'b1, 1, 1);

    for (int i = 0; i < 14; i++) begin
      drive_upd(vecs[i].flag, vecs[i].pc, vecs[i].to, vecs[i].tk, vecs[i].mis);
      if_pc = vecs[i].chk_pc;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_pred, vecs[i].exp_tk,
              vecs[i].exp_br, vecs[i].exp_mis);
    end

    // rdy=0 with a pending taken resolution for three cycles: nothing may change.
    @(negedge clk);
    rdy = 1'b0;
    br_flag = 1'b1; br_pc = 32'h1100; br_to = 32'h5000; br_taken = 1'b1; br_mispredict = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    br_flag = 1'b0; br_mispredict = 1'b0; rdy = 1'b1;
    if_pc = 32'h1100;
    #1;
    chk_all("rdy_freeze", 32'h1104, 1'b0, 12, 6);
    if_pc = 32'h1000;
    #1;
    chk("rdy_freeze.alias_pred", pred_pc, 32'h1004);

    // Reset dominates a simultaneous resolution.
    @(negedge clk);
    rst = 1'b1;
    br_flag = 1'b1; br_pc = 32'h1000; br_to = 32'h0F00; br_taken = 1'b1; br_mispredict = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; br_flag = 1'b0; br_mispredict = 1'b0;
    if_pc = 32'h1000;
    #1;
    chk_all("reset_dom", 32'h1004, 1'b0, 0, 0);
    if_pc = 32'h1100;
    #1;
    chk("reset_dom.pc1100", pred_pc, 32'h1104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-side next-PC predictor. It is the consumer of the branch-resolution interface driven by the execute stage (branch_flag / branch_pc / branch_to / branch_taken / jump_flag).
- Combinationally predicts the next fetch PC for the IF stage from a direct-mapped BTB with 2-bit saturating counters.
- Learns from the resolution stream on each clock edge.
- Keeps resolved-branch and mispredict statistics counters.

Parameters:
IDX_W, 6, index width; table has 2**IDX_W entries; index = pc[IDX_W+1:2]
TAG_W, 24, tag width (must equal 30-IDX_W); tag = pc[31:IDX_W+2]
CTR_INIT, 2'b10, counter value written on allocation (weakly taken)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
rdy  in  1  global ready; 0 freezes all state updates
if_pc  in  32  PC currently being fetched
pred_pc  out  32  predicted next fetch PC
pred_taken  out  1  1 = prediction came from a BTB hit with counter[1]=1
br_flag  in  1  execute stage resolved a control-transfer instruction this cycle
br_pc  in  32  PC of the resolved instruction
br_to  in  32  resolved next PC (target if taken, br_pc+4 if not)
br_taken  in  1  resolved direction (JAL/JALR always 1)
br_mispredict  in  1  execute stage flagged predicted PC != br_to
br_cnt  out  32  number of resolved control transfers since reset
mis_cnt  out  32  number of mispredicts since reset

Behaviour:
- Storage, per entry: valid (1), tag (TAG_W), target (32), ctr (2). pc[1:0] is ignored everywhere.
- Reset (rst=1 at posedge, dominates rdy and br_flag): all valid<=0, all ctr<=2'b01, br_cnt<=0, mis_cnt<=0. All other table contents are don't-care.
- Outputs after reset, with any if_pc: pred_pc=if_pc+4, pred_taken=0.
- Lookup (combinational, zero latency):
  - hit = valid[idx(if_pc)] && tag[idx]==tag(if_pc).
  - hit && ctr[1]: pred_pc=target[idx], pred_taken=1.
  - Otherwise: pred_pc=if_pc+4 (32-bit wrap; 0xFFFFFFFC -> 0x00000000), pred_taken=0.
- Update at posedge when rst=0, rdy=1, br_flag=1, using i=idx(br_pc):
  - Tag hit, br_taken=1: ctr saturating +1 (max 2'b11); target<=br_to.
  - Tag hit, br_taken=0: ctr saturating -1 (min 2'b00); target unchanged.
  - Miss (invalid or tag mismatch), br_taken=1: allocate. valid<=1, tag<=tag(br_pc), target<=br_to, ctr<=CTR_INIT. Any aliasing entry is overwritten.
  - Miss, br_taken=0: no table change.
  - br_cnt<=br_cnt+1. mis_cnt<=mis_cnt+1 iff br_mispredict=1. Both wrap modulo 2^32.
- br_flag=0 or rdy=0: table and counters hold. br_mispredict is ignored when br_flag=0.
- Same-cycle lookup and update of the same entry: no bypass. The lookup reflects pre-edge state; the new state is visible from the next cycle.
- Only one update per cycle; no internal pipelining; no other state machine.
- Implementation: the table must be synthesizable as registers/distributed RAM (async read, sync write).

Test Plan:
- Reset, then if_pc=0x00001000 -> pred_pc=0x00001004, pred_taken=0, br_cnt=0, mis_cnt=0.
- br_flag=1, br_pc=0x1000, br_to=0x0F00, br_taken=1, br_mispredict=1 for one cycle -> next cycle if_pc=0x1000 gives pred_pc=0x0F00, pred_taken=1; br_cnt=1, mis_cnt=1.
- Continuing: three not-taken updates at 0x1000 (br_to=0x1004) -> ctr 10->01->00->00; pred_pc=0x1004 after the first. Then two taken updates -> 01, then 10 -> pred_pc=0x0F00 again; br_cnt=6.
- Alias: taken update br_pc=0x1100, br_to=0x2000 (same index 0, different tag) -> if_pc=0x1100 predicts 0x2000; if_pc=0x1000 now predicts 0x1004. A not-taken update at miss address 0x3004 leaves its entry invalid.
- Same cycle: if_pc=br_pc=0x1000 with the first taken update -> that cycle pred_pc=0x1004, next cycle 0x0F00.
- rdy=0 with br_flag=1 for 3 cycles -> table, br_cnt and mis_cnt unchanged. Then rst=1 with br_flag=1 -> everything cleared; if_pc=0x1000 predicts 0x1004.
